// File: rtl/gpio_arb_pkg.sv
// Shared types and GPIO register map for the GPIO APB arbiter and its benches.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } arb_state_t;

    localparam logic [11:0] GPIO_DATA_IN    = 12'h000;
    localparam logic [11:0] GPIO_DATA_OUT   = 12'h004;
    localparam logic [11:0] GPIO_DIR        = 12'h008;
    localparam logic [11:0] GPIO_IRQ_EN     = 12'h00C;
    localparam logic [11:0] GPIO_IRQ_TYPE   = 12'h010;
    localparam logic [11:0] GPIO_IRQ_POL    = 12'h014;
    localparam logic [11:0] GPIO_IRQ_STATUS = 12'h018;
    localparam logic [11:0] GPIO_IRQ_CLR    = 12'h01C;
    localparam logic [11:0] GPIO_DEBOUNCE   = 12'h020;

    // Round-robin successor of requester g among n requesters.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping.
module gpio_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int k;
        k     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!any && req[k]) begin
                grant[k] = 1'b1;
                idx      = PW'(k);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Round-robin sharing of the GPIO APB slave port among NREQ single-beat requesters.
// Defining GPIO_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog that forces an error response.
module gpio_apb_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int APB_AW         = 12,
    parameter int APB_DW         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_apb,
    input  logic                   rst_apb_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*APB_AW-1:0] req_addr,
    input  logic [NREQ*APB_DW-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [APB_DW-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [APB_AW-1:0]      paddr,
    output logic                   pwrite,
    output logic [APB_DW-1:0]      pwdata,
    output logic                   psel,
    output logic                   penable,
    input  logic [APB_DW-1:0]      prdata,
    input  logic                   pready,
    input  logic                   pslverr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
        $error("gpio_apb_arbiter: unsupported NREQ or TIMEOUT_CYCLES");
    end

    arb_state_t                   state;
    logic [PW-1:0]                ptr, gidx, gidx_q;
    logic [NREQ-1:0]              grant;
    logic                         any_req;
    logic                         done, done_err;
    logic [APB_DW-1:0]            done_data;
    logic [NREQ-1:0][APB_AW-1:0]  addr_v;
    logic [NREQ-1:0][APB_DW-1:0]  wdata_v;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    gpio_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any_req)
    );

    // Accept only while idle; gated by reset so nothing is acknowledged in reset.
    assign req_ready = (state == ARB_IDLE && rst_apb_n) ? grant : '0;

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
    logic [TW-1:0] tmo_cnt;
`endif

    // Completion of the ACCESS phase: slave ready, or watchdog expiry when enabled.
    always_comb begin
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;
        if (state == ARB_ACCESS) begin
            if (pready) begin
                done      = 1'b1;
                done_err  = pslverr;
                done_data = pwrite ? '0 : prdata;
            end
`ifdef GPIO_ARB_TIMEOUT_EN
            else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                done     = 1'b1;
                done_err = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_apb or negedge rst_apb_n) begin
        if (!rst_apb_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gidx_q    <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef GPIO_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        gidx_q <= gidx;
                        ptr    <= PW'(rr_next(int'(gidx), NREQ));
                        paddr  <= addr_v[gidx];
                        pwdata <= wdata_v[gidx];
                        pwrite <= req_write[gidx];
                        psel   <= 1'b1;
                        state  <= ARB_SETUP;
                    end
                end
                ARB_SETUP: begin
                    penable <= 1'b1;
                    state   <= ARB_ACCESS;
`ifdef GPIO_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ARB_ACCESS: begin
                    if (done) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        paddr     <= '0;
                        pwrite    <= 1'b0;
                        pwdata    <= '0;
                        rsp_valid <= NREQ'(1) << gidx_q;
                        rsp_rdata <= done_data;
                        rsp_err   <= done_err;
                        state     <= ARB_IDLE;
                    end
`ifdef GPIO_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Scoreboard bench for gpio_apb_arbiter: random requesters, GPIO register slave, spec-level model.
// Define GPIO_ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_gpio_apb_arbiter;
    import gpio_arb_pkg::*;

    localparam int NREQ = 3, AW = 12, DW = 32, TMO = 8;

    logic clk_apb = 1'b0, rst_apb_n = 1'b0;
    logic [NREQ-1:0] req_valid, req_ready, req_write, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, pwdata, prdata;
    logic [AW-1:0] paddr;
    logic rsp_err, pwrite, psel, penable, pready, pslverr;

    gpio_apb_arbiter #(.NREQ(NREQ), .APB_AW(AW), .APB_DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_apb(clk_apb), .rst_apb_n(rst_apb_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk_apb = ~clk_apb;

    typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;
    typedef struct { int g; logic [DW-1:0] rdata; logic err; int gcyc; int lat; } exp_t;

    txn_t dq[NREQ][$];
    exp_t expq[$];
    int   glog[$];
    logic [DW-1:0] mregs[0:8], sregs[0:8];
    logic [DW-1:0] gpio_in = '0;
    int   checks = 0, errors = 0, cyc = 0, waits = 1, wcnt = 0, mptr = 0, gcyc_last = -1;
    bit   busy = 0, drv_en = 0, drop_en = 0, stall = 0, prev_psel = 0;
    logic [AW-1:0] cur_a;
    logic          cur_w;
    logic [DW-1:0] cur_d;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit mapped(input logic [AW-1:0] a);
        return a[1:0] == 2'b00 && a <= GPIO_DEBOUNCE;
    endfunction

    // Round-robin rule: first pending requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < NREQ; k++) n += dq[k].size();
        return n;
    endfunction

    task automatic push(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.w = w; t.a = a; t.d = d;
        dq[k].push_back(t);
    endtask

    always @(posedge clk_apb) cyc++;

    // GPIO register slave: `waits` wait states, random pready/pslverr/prdata outside ACCESS.
    always @(posedge clk_apb) begin
        #1;
        if (psel && penable && !stall) begin
            if (wcnt >= waits) begin
                pready  = 1'b1;
                pslverr = !mapped(paddr);
                if (pwrite) begin
                    prdata = $urandom;
                    if (mapped(paddr) && paddr != GPIO_DATA_IN) sregs[paddr >> 2] = pwdata;
                end else begin
                    prdata = !mapped(paddr) ? '0 : (paddr == GPIO_DATA_IN ? gpio_in : sregs[paddr >> 2]);
                end
                wcnt = 0;
            end else begin
                pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom; wcnt++;
            end
        end else begin
            wcnt    = 0;
            pready  = (psel && penable) ? 1'b0 : 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end
    end

    // Requester drivers: hold a request until accepted, optionally drop it for a cycle.
    logic [NREQ-1:0] acc;
    always begin
        @(negedge clk_apb);
        acc = req_valid & req_ready;
        @(posedge clk_apb);
        #2;
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k] && dq[k].size() > 0) void'(dq[k].pop_front());
            if (drv_en && dq[k].size() > 0 && !(drop_en && $urandom_range(0, 5) == 0)) begin
                req_valid[k] = 1'b1;
                req_write[k] = dq[k][0].w;
                req_addr[k*AW +: AW]  = dq[k][0].a;
                req_wdata[k*DW +: DW] = dq[k][0].d;
            end else begin
                req_valid[k] = 1'b0;
            end
        end
    end

    // Reference model: predicts grants and pushes the expected response.
    int            g_m;
    exp_t          e_m;
    logic [AW-1:0] a_m;
    logic          w_m;
    logic [DW-1:0] d_m;
    always @(negedge clk_apb) begin
        if (!rst_apb_n) begin
            busy = 0; mptr = 0; gcyc_last = -1;
            expq.delete(); glog.delete();
        end else begin
            if (rsp_valid != '0) busy = 0;
            if (!busy && req_valid != '0) begin
                g_m = pick(req_valid, mptr);
                chk("grant", 64'(req_ready), 64'(1) << g_m);
                if (gcyc_last >= 0) chk("grant_gap_ge3", 64'((cyc - gcyc_last) >= 3), 64'(1));
                a_m = req_addr[g_m*AW +: AW];
                w_m = req_write[g_m];
                d_m = req_wdata[g_m*DW +: DW];
                e_m.g = g_m; e_m.gcyc = cyc;
                if (stall) begin
                    e_m.lat = 2 + TMO; e_m.err = 1'b1; e_m.rdata = '0;
                end else begin
                    e_m.lat = 3 + waits; e_m.err = !mapped(a_m);
                    if (w_m) begin
                        e_m.rdata = '0;
                        if (mapped(a_m) && a_m != GPIO_DATA_IN) mregs[a_m >> 2] = d_m;
                    end else begin
                        e_m.rdata = !mapped(a_m) ? '0 : (a_m == GPIO_DATA_IN ? gpio_in : mregs[a_m >> 2]);
                    end
                end
                expq.push_back(e_m);
                glog.push_back(g_m);
                cur_a = a_m; cur_w = w_m; cur_d = d_m;
                busy = 1; gcyc_last = cyc; mptr = (g_m + 1) % NREQ;
            end else begin
                chk("no_grant", 64'(req_ready), 64'(0));
            end
        end
    end

    // Monitor: APB phase checks and response scoreboard.
    exp_t e_c;
    always @(negedge clk_apb) begin
        if (!rst_apb_n) begin
            chk("rst_psel", 64'(psel), 64'(0));
            chk("rst_penable", 64'(penable), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_paddr", 64'(paddr), 64'(0));
        end else begin
            if (psel) begin
                chk("penable_seq", 64'(penable), 64'(prev_psel));
                chk("paddr", 64'(paddr), 64'(cur_a));
                chk("pwrite", 64'(pwrite), 64'(cur_w));
                if (cur_w) chk("pwdata", 64'(pwdata), 64'(cur_d));
            end else begin
                chk("idle_penable", 64'(penable), 64'(0));
                chk("idle_paddr", 64'(paddr), 64'(0));
            end
            if (rsp_valid != '0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e_c = expq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(1) << e_c.g);
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_c.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e_c.err));
                    chk("rsp_latency", 64'(cyc - e_c.gcyc), 64'(e_c.lat));
                end
            end
        end
        prev_psel = psel && rst_apb_n;
    end

    task automatic drain();
        int n = 0;
        while ((pending() != 0 || expq.size() != 0 || busy) && n < 3000) begin
            @(negedge clk_apb);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d expq=%0d busy=%0d", pending(), expq.size(), busy);
        end
        repeat (2) @(negedge clk_apb);
    endtask

    initial begin
        int sel, n;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        for (int i = 0; i < 9; i++) begin mregs[i] = '0; sregs[i] = '0; end

        // Single write + readback, with the request already pending during reset.
        push(0, 1'b1, GPIO_DATA_OUT, 32'hA5A5_0001);
        push(0, 1'b0, GPIO_DATA_OUT, '0);
        drv_en = 1;
        repeat (4) @(posedge clk_apb);
        #3 rst_apb_n = 1'b1;
        drain();
        chk("slave_data_out", 64'(sregs[1]), 64'h0000_0000_A5A5_0001);

        // Unmapped read from requester 1.
        push(1, 1'b0, 12'h03C, '0);
        drain();

        // Back-to-back reads of DATA_IN.
        gpio_in = 32'h1234_5678;
        repeat (4) push(2, 1'b0, GPIO_DATA_IN, '0);
        drain();

        // Random traffic at 0, 1 and 2 wait states with request drops.
        drop_en = 1;
        for (int ph = 0; ph < 3; ph++) begin
            waits = ph;
            gpio_in = $urandom;
            for (int t = 0; t < 15; t++) begin
                sel = $urandom_range(0, 11);
                push($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)),
                     sel < 9 ? AW'(sel * 4) : (sel == 9 ? 12'h03C : (sel == 10 ? 12'h006 : 12'h100)),
                     $urandom);
            end
            drain();
        end
        drop_en = 0;

        // Reset during ACCESS.
        waits = 3;
        push(2, 1'b0, GPIO_DIR, '0);
        n = 0;
        while (!(psel && penable) && n < 200) begin @(negedge clk_apb); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL access_wait_timeout"); end
        #1 rst_apb_n = 1'b0;
        drv_en = 0;
        for (int k = 0; k < NREQ; k++) dq[k].delete();
        #1;
        chk("midrst_psel", 64'(psel), 64'(0));
        chk("midrst_penable", 64'(penable), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) @(posedge clk_apb);
        #3 rst_apb_n = 1'b1;
        waits = 1;
        drv_en = 1;

        // All three requesting after reset: grant order restarts at requester 0.
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NREQ; k++) push(k, 1'b0, AW'(4 * (k + 1)), '0);
        drain();
        chk("rr_count", 64'(glog.size()), 64'(6));
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(i % NREQ));

`ifdef GPIO_ARB_TIMEOUT_EN
        stall = 1;
        push(1, 1'b0, GPIO_DATA_OUT, '0);
        drain();
        stall = 0;
        push(2, 1'b0, GPIO_DATA_OUT, '0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
